gnn_layer_ctrl: RTL

GNN_LAYER_CTRL -- requirements
Module: gnn_layer_ctrl

---
 rtl/gnn_pkg.sv | 22 ++
 rtl/gnn_watchdog.sv | 40 ++++
 rtl/gnn_layer_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/gnn_pkg.sv
// Shared types and constants for the GNN layer sequencer.
// Holds the FSM state encoding and the layer-index width.
package gnn_pkg;

  localparam int LAYER_IDX_W    = 3;
  localparam int DEF_NUM_LAYERS = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_AGG,
    WAIT_AGG,
    ISSUE_COMB,
    WAIT_COMB,
    FINISH,
    ERROR
  } state_e;

  function automatic logic is_wait(state_e s);
    return (s == WAIT_AGG) || (s == WAIT_COMB);
  endfunction

endpackage

// File: rtl/gnn_watchdog.sv
// Wait-state timeout counter for the GNN layer sequencer.
// Ports: clk, rst_n, clear (zero count), enable (count this
// cycle), expired (enabled and count at TIMEOUT_CYCLES-1).
module gnn_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires on the last allowed wait cycle so the FSM leaves
  // after exactly TIMEOUT_CYCLES cycles in the wait state.
  assign expired = enable && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gnn_layer_ctrl.sv
// Sequencer issuing aggregate/combine passes per GNN layer.
// Ports: clk, rst_n (async low), start, abort; agg_start/
// agg_done and comb_start/comb_done handshakes; feat_sel,
// layer_idx, busy, done, err (sticky timeout).
// Optional: GNN_CTRL_WATCHDOG_EN adds the wait-state timeout.
module gnn_layer_ctrl
  import gnn_pkg::*;
#(
  parameter int NUM_LAYERS     = DEF_NUM_LAYERS,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   agg_start,
  input  logic                   agg_done,
  output logic                   comb_start,
  input  logic                   comb_done,
  output logic                   feat_sel,
  output logic [LAYER_IDX_W-1:0] layer_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  if (NUM_LAYERS < 1 || NUM_LAYERS > 8 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("gnn_layer_ctrl: parameter out of range");
  end

  localparam logic [LAYER_IDX_W-1:0] LAST =
    LAYER_IDX_W'(NUM_LAYERS - 1);

  state_e                 state_q, state_d;
  logic [LAYER_IDX_W-1:0] layer_q, layer_d;
  logic                   start_q;
  logic                   start_req;
  logic                   agg_start_q;
  logic                   comb_start_q;
  logic                   feat_sel_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   wd_expired;

  // Only a rising edge launches an inference, so a start
  // held high across completion does not relaunch.
  assign start_req = start && !start_q;

`ifdef GNN_CTRL_WATCHDOG_EN
  logic wd_en;
  logic err_q, err_d;

  assign wd_en = is_wait(state_q);
  assign err   = err_q;

  gnn_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!wd_en),
    .enable (wd_en),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
`ifdef GNN_CTRL_WATCHDOG_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = ISSUE_AGG;
          layer_d = '0;
`ifdef GNN_CTRL_WATCHDOG_EN
          err_d   = 1'b0;
`endif
        end
      end
      ISSUE_AGG: state_d = WAIT_AGG;
      WAIT_AGG: begin
        if (agg_done) begin
          state_d = ISSUE_COMB;
        end else if (wd_expired) begin
          state_d = ERROR;
        end
      end
      ISSUE_COMB: state_d = WAIT_COMB;
      WAIT_COMB: begin
        if (comb_done) begin
          if (layer_q == LAST) begin
            state_d = FINISH;
          end else begin
            state_d = ISSUE_AGG;
            layer_d = layer_q + LAYER_IDX_W'(1);
          end
        end else if (wd_expired) begin
          state_d = ERROR;
        end
      end
      FINISH: state_d = IDLE;
      ERROR: begin
        state_d = IDLE;
        layer_d = '0;
`ifdef GNN_CTRL_WATCHDOG_EN
        err_d   = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides every transition above, including
    // a done arriving in the same cycle.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      layer_d = '0;
    end
  end

  // Outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      layer_q      <= '0;
      start_q      <= 1'b0;
      agg_start_q  <= 1'b0;
      comb_start_q <= 1'b0;
      feat_sel_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      start_q      <= start;
      agg_start_q  <= (state_d == ISSUE_AGG);
      comb_start_q <= (state_d == ISSUE_COMB);
      feat_sel_q   <= (layer_d != '0);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == FINISH);
    end
  end

`ifdef GNN_CTRL_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  assign agg_start  = agg_start_q;
  assign comb_start = comb_start_q;
  assign feat_sel   = feat_sel_q;
  assign layer_idx  = layer_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
